// File: rtl/tt_capture_if.sv
// Truth-table word stream: producer presents 8-bit words with valid/last;
// consumer accepts a word on valid & ready.
interface tt_capture_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input  out_data, input  out_valid, input  out_last, output out_ready);
endinterface

// File: rtl/tt_capture.sv
// Exhaustively drives every input vector of a combinational circuit, samples its
// output after a settle delay, then streams the resulting truth table as 8-bit words.
module tt_capture #(
  parameter int N_IN   = 8,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] pi_drv,
  input  logic            po_in,
  output logic            busy,
  output logic [N_IN:0]   ones_count,
  output logic            done,
  tt_capture_if.master    out
);
  localparam int NV = 1 << N_IN;
  localparam int NW = NV / 8;
  localparam int KW = (N_IN > 3) ? N_IN - 3 : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_STREAM} state_t;

  state_t          state_q;
  logic [N_IN-1:0] pi_q;
  logic [3:0]      cnt_q;
  logic [N_IN:0]   acc_q;
  logic [N_IN:0]   ones_q;
  logic [KW-1:0]   k_q;
  logic            valid_q;
  logic            done_q;
  logic [NV-1:0]   tt_q;

  logic [N_IN:0]   acc_d;
  logic            last_vec;
  logic            last_word;
  logic            accept;
  logic [N_IN-1:0] word_base;

  assign acc_d     = acc_q + (N_IN+1)'(po_in);
  assign last_vec  = (pi_q == {N_IN{1'b1}});
  assign last_word = (k_q == KW'(NW - 1));
  assign accept    = valid_q && out.out_ready;
  assign word_base = N_IN'({k_q, 3'b000});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pi_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ones_q  <= '0;
      k_q     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          pi_q    <= '0;
          cnt_q   <= 4'(SETTLE - 1);
          acc_q   <= '0;
          state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == 4'd0) state_q <= S_SAMPLE;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        S_SAMPLE: begin
          acc_q <= acc_d;
          if (last_vec) begin
            ones_q  <= acc_d;
            k_q     <= '0;
            valid_q <= 1'b1;
            state_q <= S_STREAM;
          end else begin
            pi_q    <= pi_q + N_IN'(1);
            cnt_q   <= 4'(SETTLE - 1);
            state_q <= S_SETTLE;
          end
        end
        S_STREAM: if (accept) begin
          if (last_word) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Table storage needs no reset: it is only visible after a full capture rewrites it.
  always_ff @(posedge clk) begin
    if (state_q == S_SAMPLE) tt_q[pi_q] <= po_in;
  end

  assign pi_drv       = pi_q;
  assign busy         = (state_q != S_IDLE);
  assign ones_count   = ones_q;
  assign done         = done_q;
  assign out.out_valid = valid_q;
  assign out.out_data  = valid_q ? tt_q[word_base +: 8] : 8'h00;
  assign out.out_last  = valid_q && last_word;
endmodule

// File: tb/tb_tt_capture.sv
// Drives tt_capture with random and directed truth tables and checks the
// capture timing and streamed words against a table-based reference.
module tb_tt_capture;
  localparam int N   = 8;
  localparam int S   = 2;
  localparam int NV  = 1 << N;
  localparam int NW  = NV / 8;
  localparam int CAP = NV * (S + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  pi_drv;
  logic          po_in;
  logic          busy;
  logic [N:0]    ones_count;
  logic          done;
  logic [NV-1:0] tt;

  logic          start2 = 1'b0;
  logic [2:0]    pi2;
  logic          po2;
  logic          busy2;
  logic [3:0]    ones2;
  logic          done2;

  int checks = 0;
  int failures = 0;
  int prev_ones = 0;

  tt_capture_if ifc ();
  tt_capture_if ifc2 ();

  always #5 clk = ~clk;

  assign po_in = tt[pi_drv];
  assign po2   = pi2[0];

  tt_capture #(.N_IN(N), .SETTLE(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pi_drv(pi_drv), .po_in(po_in),
    .busy(busy), .ones_count(ones_count), .done(done), .out(ifc.master)
  );

  tt_capture #(.N_IN(3), .SETTLE(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .pi_drv(pi2), .po_in(po2),
    .busy(busy2), .ones_count(ones2), .done(done2), .out(ifc2.master)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pi"}, 32'(pi_drv), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_valid"}, 32'(ifc.out_valid), 0);
    chk({tag, "_last"}, 32'(ifc.out_last), 0);
    chk({tag, "_data"}, 32'(ifc.out_data), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ones"}, 32'(ones_count), 0);
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 5 cycles on word 3
  task automatic run(input int mode, input bit glitch);
    int c, idx, stall, exp_ones;
    bit rdy, hold_pend;
    logic [7:0] hold_data, exp_word;
    logic hold_last;
    exp_ones = $countones(tt);
    idx = 0; stall = 0; hold_pend = 0; hold_data = '0; hold_last = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    c = 1;
    chk("ones_hold_prev_run", 32'(ones_count), 32'(prev_ones));
    while (idx < NW && c < CAP + 4000) begin
      if (c <= CAP) begin
        if (c % 37 == 1 || c == CAP) begin
          chk("pi_seq", 32'(pi_drv), 32'((c - 1) / (S + 1)));
          chk("busy_cap", 32'(busy), 1);
          chk("valid_cap", 32'(ifc.out_valid), 0);
        end
      end
      if (c == CAP + 1) begin
        chk("first_valid", 32'(ifc.out_valid), 1);
        chk("ones_count", 32'(ones_count), 32'(exp_ones));
        chk("pi_hold", 32'(pi_drv), 32'(NV - 1));
      end
      start = (glitch && (c == 100 || c == CAP + 5)) ? 1'b1 : 1'b0;
      if (ifc.out_valid) begin
        if (hold_pend) begin
          chk("hold_data", 32'(ifc.out_data), 32'(hold_data));
          chk("hold_last", 32'(ifc.out_last), 32'(hold_last));
        end
        case (mode)
          0: rdy = 1'b1;
          1: rdy = 1'($urandom_range(0, 1));
          default: begin
            rdy = !(idx == 3 && stall < 5);
            if (!rdy) stall++;
          end
        endcase
        ifc.out_ready = rdy;
        if (rdy) begin
          exp_word = tt[idx*8 +: 8];
          chk("word_data", 32'(ifc.out_data), 32'(exp_word));
          chk("word_last", 32'(ifc.out_last), 32'(idx == NW - 1));
          idx++;
          hold_pend = 1'b0;
        end else begin
          hold_pend = 1'b1;
          hold_data = ifc.out_data;
          hold_last = ifc.out_last;
        end
      end else begin
        ifc.out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk); c++;
    end
    start = 1'b0;
    chk("words_received", 32'(idx), 32'(NW));
    if (mode == 2) chk("stall_cycles", 32'(stall), 5);
    chk("done_pulse", 32'(done), 1);
    chk("valid_after", 32'(ifc.out_valid), 0);
    chk("busy_after", 32'(busy), 0);
    @(negedge clk);
    chk("done_single", 32'(done), 0);
    prev_ones = exp_ones;
  endtask

  initial begin
    int c2;
    ifc.out_ready = 1'b1;
    ifc2.out_ready = 1'b1;
    tt = '0;
    #1;
    chk_reset_outputs("reset");
    #20; @(negedge clk); rst_n = 1'b1;

    // Directed: po = &pi[3:0] & ~&pi[7:4]
    for (int v = 0; v < NV; v++) tt[v] = (v[3:0] == 4'hF) && (v[7:4] != 4'hF);
    run(0, 0);
    chk("ones_directed", 32'(ones_count), 15);

    tt = '1;
    run(1, 0);
    chk("ones_all1", 32'(ones_count), 256);

    tt = '0;
    run(0, 0);
    chk("ones_all0", 32'(ones_count), 0);

    for (int v = 0; v < NV; v++) tt[v] = 1'($urandom_range(0, 1));
    run(2, 0);

    for (int v = 0; v < NV; v++) tt[v] = 1'($urandom_range(0, 1));
    run(1, 1);

    // Abort mid-capture, then a clean run
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (299) @(negedge clk);
    chk("busy_before_abort", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    @(negedge clk); rst_n = 1'b1;
    prev_ones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("idle_valid", 32'(ifc.out_valid), 0);
      chk("idle_done", 32'(done), 0);
    end
    for (int v = 0; v < NV; v++) tt[v] = 1'($urandom_range(0, 1));
    run(0, 0);

    // Small instance: N_IN=3, SETTLE=1, po = pi0
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    c2 = 1;
    while (!ifc2.out_valid && c2 < 200) begin
      @(negedge clk); c2++;
    end
    chk("small_first_valid", 32'(c2), 17);
    chk("small_data", 32'(ifc2.out_data), 32'h AA);
    chk("small_last", 32'(ifc2.out_last), 1);
    chk("small_ones", 32'(ones2), 4);
    @(negedge clk);
    chk("small_done", 32'(done2), 1);
    chk("small_busy", 32'(busy2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tt_capture.md
TT_CAPTURE -- requirements
Module: tt_capture

Interface
REQ-001 Parameter N_IN, default 8, range 3..10: number of circuit primary inputs driven and characterised.
REQ-002 Parameter SETTLE, default 2, range 1..15: cycles each input vector is held before po_in is sampled.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  one-cycle request to begin a characterisation run; honoured only in IDLE.
REQ-006 pi_drv  output  N_IN  vector driven to circuit inputs; bit i drives pi<i>.
REQ-007 po_in  input  1  circuit output po0 under test, combinational from pi_drv.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 out_data  output  8  truth-table word; bit j of word k equals response for vector 8k+j.
REQ-010 out_valid  output  1  out_data is valid.
REQ-011 out_ready  input  1  consumer accepts the word when out_valid and out_ready are both high.
REQ-012 out_last  output  1  high with the final word, index 2^N_IN/8-1.
REQ-013 ones_count  output  N_IN+1  number of vectors for which po_in sampled 1 in the last completed capture.
REQ-014 done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-015 FSM states: IDLE, SETTLE, SAMPLE, STREAM, and nothing else.
REQ-016 IDLE with start=1: pi_drv<=0, settle counter<=SETTLE-1, ones accumulator<=0, next state SETTLE; start=0 holds IDLE.
REQ-017 SETTLE: counter decrements each cycle; at counter==0, next state SAMPLE. pi_drv is held constant.
REQ-018 SAMPLE: buf[pi_drv]<=po_in; accumulator += po_in; lasts exactly one cycle.
REQ-019 SAMPLE with pi_drv<2^N_IN-1: pi_drv increments, counter reloads SETTLE-1, next state SETTLE.
REQ-020 SAMPLE with pi_drv==2^N_IN-1: ones_count<=final accumulator including this sample, word index<=0, next state STREAM; pi_drv holds.
REQ-021 Each vector occupies exactly SETTLE+1 cycles. Capture length is 2^N_IN*(SETTLE+1) cycles: 768 at defaults.
REQ-022 STREAM: out_valid=1; out_data=buf[8k+7:8k] for word index k; out_last=(k==2^N_IN/8-1).
REQ-023 While out_valid=1 and out_ready=0, out_data and out_last hold stable and k does not advance.
REQ-024 Accept on a non-last word: k increments and the next word is presented the following cycle. No bubble is required.
REQ-025 Accept on the last word: next state IDLE, out_valid=0, done=1 for exactly that next cycle.
REQ-026 start asserted while busy=1 is ignored with no side effect.
REQ-027 The accumulator never wraps; its width N_IN+1 holds 2^N_IN.
REQ-028 ones_count is updated only at REQ-020 and holds until the next run completes capture.

Reset
REQ-029 rst_n low asynchronously forces IDLE and clears outputs: pi_drv=0, busy=0, out_valid=0, out_last=0, out_data=0, done=0, ones_count=0, counters=0.
REQ-030 Reset asserted mid-capture or mid-stream aborts the run. After release, the block waits in IDLE for a new start, and no stale word or done pulse is emitted.
REQ-031 Truth-table buffer contents are not reset. They are never observable before being overwritten by a full capture.

Verification
REQ-032 po_in = &pi[3:0] & ~&pi[7:4], defaults, out_ready=1 -> 32 words. Words 1,3,...,29 are 0x80; words 31 and all even words are 0x00; ones_count=15; done pulses once, one cycle after the accept of word 31.
REQ-033 po_in tied 1 -> all 32 words 0xFF, ones_count=256. po_in tied 0 -> all words 0x00, ones_count=0.
REQ-034 out_ready low 5 cycles while word 3 is presented -> out_data and out_last unchanged all 5 cycles; words 4..31 follow in order; no word is lost or duplicated.
REQ-035 rst_n pulsed low at cycle 300 of capture -> all outputs immediately return to reset values. A following start produces a full, correct 32-word stream.
REQ-036 start pulsed at capture cycle 100 and during STREAM -> no restart; pi_drv sequence, word order and completion time are identical to an undisturbed run.
REQ-037 N_IN=3, SETTLE=1, po_in=pi0 -> 16 capture cycles, then a single word 0xAA with out_last=1; ones_count=4.
